// File: rtl/traffic_lamp_ctrl.sv
// traffic_lamp_ctrl
//   Single-junction traffic lamp sequencer: RED -> GREEN -> YELLOW -> RED with
//   per-colour dwell times, a run/freeze enable, a pedestrian request that
//   shortens GREEN, and a flashing-yellow night mode. All outputs are registered.
//
//   Ports:
//     clock      - rising-edge system clock
//     reset_n    - asynchronous active-low reset
//     enable     - 1 = run, 0 = freeze counter/state (ped_req still captured)
//     flash_mode - 1 = night mode (flashing yellow)
//     ped_req    - pedestrian request, level or pulse
//     light      - one-hot lamp drive {R,G,Y}
//     phase      - current state (RED=0, GREEN=1, YELLOW=2, FLASH=3)
//     remaining  - dwell down-counter (cycles left in state, minus 1)
//     ped_ack    - one-cycle pulse when a pending request is served
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   RED    | stop; dwell RED_TIME cycles, pedestrian requests ignored
//   GREEN  | go; dwell GREEN_TIME cycles, may be cut to PED_MIN_GREEN
//   YELLOW | clearance; dwell YELLOW_TIME cycles, serves pending request
//   FLASH  | night mode; light toggles YELLOW/OFF every FLASH_HALF cycles

module traffic_lamp_ctrl #(
  parameter int CNT_W         = 8,
  parameter int RED_TIME      = 10,
  parameter int GREEN_TIME    = 8,
  parameter int YELLOW_TIME   = 3,
  parameter int PED_MIN_GREEN = 2,
  parameter int FLASH_HALF    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flash_mode,
  input  logic             ped_req,
  output logic [2:0]       light,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_ack
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  // Dwell times are held as TIME-1 so that TIME = 2^CNT_W still fits.
  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TIME - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] PED_LOAD    = CNT_W'(PED_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       light_q, light_d;
  logic             pend_q, pend_d;
  logic             tog_q, tog_d;
  logic             ack_q, ack_d;
  logic             pend_set;
  logic             tc;

  assign pend_set = ped_req && ((state_q == S_GREEN) || (state_q == S_YELLOW));
  assign tc       = (cnt_q == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RED;
      cnt_q   <= RED_LOAD;
      light_q <= LAMP_RED;
      pend_q  <= 1'b0;
      tog_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      light_q <= light_d;
      pend_q  <= pend_d;
      tog_q   <= tog_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    light_d = light_q;
    pend_d  = pend_q;
    tog_d   = tog_q;
    ack_d   = 1'b0;

    if (flash_mode && (state_q != S_FLASH)) begin
      state_d = S_FLASH;
      cnt_d   = FLASH_LOAD;
      light_d = LAMP_YELLOW;
      pend_d  = 1'b0;
      tog_d   = 1'b0;
    end else if (!flash_mode && (state_q == S_FLASH)) begin
      // Leaving night mode restarts the cycle from a full RED.
      state_d = S_RED;
      cnt_d   = RED_LOAD;
      light_d = LAMP_RED;
      pend_d  = 1'b0;
      tog_d   = 1'b0;
    end else if (!enable) begin
      pend_d = pend_q | pend_set;
    end else begin
      case (state_q)
        S_RED: begin
          if (tc) begin
            state_d = S_GREEN;
            cnt_d   = GREEN_LOAD;
            light_d = LAMP_GREEN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_GREEN: begin
          pend_d = pend_q | pend_set;
          // Shortening can only fire once: afterwards cnt_q <= PED_LOAD.
          if (pend_q && (cnt_q > PED_LOAD)) begin
            cnt_d = PED_LOAD;
          end else if (tc) begin
            state_d = S_YELLOW;
            cnt_d   = YELLOW_LOAD;
            light_d = LAMP_YELLOW;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_YELLOW: begin
          if (tc) begin
            state_d = S_RED;
            cnt_d   = RED_LOAD;
            light_d = LAMP_RED;
            ack_d   = pend_q;
            // A request arriving on this very edge is covered by this RED.
            pend_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q - CNT_ONE;
            pend_d = pend_q | pend_set;
          end
        end
        S_FLASH: begin
          if (tc) begin
            tog_d   = ~tog_q;
            light_d = tog_q ? LAMP_YELLOW : LAMP_OFF;
            cnt_d   = FLASH_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_RED;
          cnt_d   = RED_LOAD;
          light_d = LAMP_RED;
          pend_d  = 1'b0;
          tog_d   = 1'b0;
        end
      endcase
    end
  end

  assign light     = light_q;
  assign phase     = state_q;
  assign remaining = cnt_q;
  assign ped_ack   = ack_q;

endmodule
